axi_write_data_channel: RTL and testbench
=========================================

# axi_write_data_channel

AXI4 write-data/write-response master stage sitting directly downstream of the address-control channel on the write path. Once `AxVALID`/`AxREADY` completes on the AW channel, a `go` here streams `burst_length` beats from a local valid/ready source onto W, asserts `WLAST` on the final beat, then collects the B response. It reports `done`/`error` with the same handshake semantics as the address stage, so one controller can sequence both.

## Interface
Parameters:
- `DATA_WIDTH`, 32, W data width in bits; power of two, 32..1024.
- `RESP_TIMEOUT`, 1024, B-response timeout in cycles; used only with `AXI_WRITE_RESP_TIMEOUT_EN`.

Ports:
- Reset and clock: `resetn`, synchronous, active-low; clock `clk`.
- `clk`  in  1  clock.
- `resetn`  in  1  synchronous active-low reset.
- `go`  in  1  start request; level, held until `done`.
- `burst_length`  in  int  beats, legal 1..256.
- `burst_size`  in  int  bytes per beat, legal 1,2,4,…,`DATA_WIDTH/8`.
- `src_data`  in  `DATA_WIDTH`  beat payload.
- `src_valid`  in  1  source has a beat.
- `src_ready`  out  1  stage accepts `src_data` this cycle.
- `WDATA`  out  `DATA_WIDTH`  write data.
- `WSTRB`  out  `DATA_WIDTH/8`  byte strobes.
- `WLAST`  out  1  last beat of burst.
- `WVALID`  out  1  W valid.
- `WREADY`  in  1  W ready.
- `BRESP`  in  2  write response.
- `BVALID`  in  1  B valid.
- `BREADY`  out  1  B ready.
- `done`  out  1  burst finished (ok or error).
- `error`  out  1  burst failed.
- `error_resp`  out  2  `BRESP` captured on failure; `2'b00` for parameter errors.
- `current_state_out`  out  3  state encoding, for debug.

## Operation
- **States and encodings:** `RESET` 000, `IDLE` 001, `STREAM` 010, `WAIT_RESP` 011, `COMPLETE` 100, `ERROR` 101. Any other encoding moves to `RESET`.
- `RESET` -> `IDLE` unconditionally.
- **`IDLE`:**
  - On `go=1` with legal `burst_size` and `burst_length`: latch both and go to `STREAM`. Beat counter loads `burst_length-1`, 8 bits.
  - On `go=1` with illegal values: go to `ERROR`, `error_resp=00`.
- **`STREAM`:**
  - Single output register stage. `src_ready = (!WVALID || WREADY) && beats_issued < burst_length`.
  - On `src_valid && src_ready`: load `WDATA`, set `WVALID=1`, set `WLAST = (count==0)`, decrement `count`.
  - On `WVALID && WREADY` with no new load: clear `WVALID`.
  - Last W handshake (`WLAST && WREADY`) -> `WAIT_RESP`.
- **`WSTRB`:** low `burst_size` lanes set; all others 0. Fixed for the burst.
- **`WAIT_RESP`:**
  - `BREADY=1`.
  - On `BVALID`: `BRESP[1]==0` (OKAY/EXOKAY) -> `COMPLETE`; otherwise -> `ERROR` with `error_resp=BRESP`.
- **`COMPLETE`:** `done=1`; on `go=0` -> `IDLE`.
- **`ERROR`:** `done=1`, `error=1`; on `go=0` -> `IDLE`. `error_resp` holds until the next accepted `go`.
- `BVALID` during `STREAM` is ignored (`BREADY=0`). `src_valid` while not in `STREAM` is ignored.

## Timing
- **Reset values:** every output is 0 (`WDATA`, `WSTRB`, `WLAST`, `WVALID`, `BREADY`, `src_ready`, `done`, `error`, `error_resp`). `current_state_out=000` in the cycle after the reset edge.
- **Start:** `go` is sampled in `IDLE`. `src_ready` can rise the cycle after. The first `WVALID` follows a source handshake by 1 cycle.
- **Throughput:** 1 beat/cycle with `src_valid` and `WREADY` held high. A burst of N beats takes N+1 cycles from entering `STREAM` to the last W handshake.
- **Backpressure:** `WDATA`/`WLAST`/`WSTRB` are stable while `WVALID && !WREADY`.
- **`WVALID`:** never drops without a handshake.
- **`BREADY`:** high from the cycle after the last W handshake until `BVALID`, inclusive.
- **`done`:** rises 1 cycle after the B handshake.
- **Mid-burst reset:** `resetn=0` at any edge clears all state and outputs at that edge. No partial `WLAST` is emitted.

## Configuration
- **`AXI_WRITE_RESP_TIMEOUT_EN` defined:**
  - A 16-bit counter runs in `WAIT_RESP`.
  - At `RESP_TIMEOUT` cycles without `BVALID`: go to `ERROR` with `error_resp=2'b11`.
  - Counter clears on entry to `WAIT_RESP`.
- **Undefined:** `WAIT_RESP` waits indefinitely. No counter logic is present.

## Structure
- **Package `axi_wchan_pkg`:**
  - `wchan_state_t` enum with the encodings above.
  - Response constants `RESP_OKAY`, `RESP_EXOKAY`, `RESP_SLVERR`, `RESP_DECERR`.
  - Function `size_legal(burst_size, DATA_WIDTH)`.
  - Function `size_to_strb(burst_size)`.
- **Sub-module `axi_w_out_reg`:** the single-entry W output register with its ready logic. The FSM and beat counter stay in the top module.

## Test plan
- `burst_length=4`, `burst_size=4`, `src_valid` and `WREADY` always 1 -> 4 W beats on consecutive cycles, `WSTRB=4'hF`, `WLAST` only on beat 4, `BRESP=00` -> `done=1`, `error=0`.
- `burst_length=3`, `WREADY` toggling 1,0,0,1,… -> data stable while stalled, exactly 3 handshakes, no `WVALID` drop before a handshake.
- `burst_size=3` or `burst_length=257` with `go` -> `ERROR`, `error=1`, `error_resp=00`, no W activity. `go=0` -> `IDLE`.
- `burst_length=1`, `BRESP=2'b10` -> single beat with `WLAST=1`, then `error=1`, `error_resp=10`.
- Reset asserted after 2 of 8 beats -> next cycle all outputs 0, `current_state_out=000`. A new `go` then runs the full 8 beats.
- With `AXI_WRITE_RESP_TIMEOUT_EN` and `RESP_TIMEOUT=16`, `BVALID` never asserted -> `ERROR` after 16 cycles in `WAIT_RESP`, `error_resp=11`.

Source files
------------

// File: rtl/axi_wchan_pkg.sv
// axi_wchan_pkg
//   Shared types and helpers for the AXI4 write-data / write-response stage.
//   - wchan_state_t : FSM state encodings (also visible on current_state_out)
//   - RESP_*        : AXI BRESP codes
//   - size_legal    : burst_size is a power of two no wider than the data bus
//   - size_to_strb  : low burst_size byte lanes set
package axi_wchan_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'b000,
        ST_IDLE      = 3'b001,
        ST_STREAM    = 3'b010,
        ST_WAIT_RESP = 3'b011,
        ST_COMPLETE  = 3'b100,
        ST_ERROR     = 3'b101
    } wchan_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int MAX_BURST_LEN = 256;
    // Widest supported bus is 1024 bits -> 128 byte lanes.
    localparam int MAX_STRB_W    = 128;

    function automatic logic size_legal(input int burst_size, input int data_width);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if ((burst_size == (1 << k)) && ((1 << k) <= (data_width / 8))) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

    function automatic logic [MAX_STRB_W-1:0] size_to_strb(input int burst_size);
        logic [MAX_STRB_W-1:0] m;
        for (int i = 0; i < MAX_STRB_W; i++) begin
            m[i] = (i < burst_size);
        end
        return m;
    endfunction

endpackage

// File: rtl/axi_w_out_reg.sv
// axi_w_out_reg
//   Single-entry W output register. Holds WDATA/WLAST/WVALID and produces the
//   source-side ready.
//   Ports:
//     clk, resetn            clock, synchronous active-low reset
//     load_en_i              controller allows a new beat to be taken
//     last_i                 the beat taken now is the final one of the burst
//     src_data_i/src_valid_i local source beat
//     src_ready_o            register can take src_data_i this cycle
//     load_o                 source handshake happens at this edge
//     wready_i               AXI WREADY
//     wdata_o/wlast_o/wvalid_o AXI W payload and valid
//
//   Handshake rule (both sides): a transfer happens at a rising edge where
//   valid and ready are both high; valid, once raised, stays high with its
//   payload unchanged until that transfer.
module axi_w_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load_en_i,
    input  logic                  last_i,
    input  logic [DATA_WIDTH-1:0] src_data_i,
    input  logic                  src_valid_i,
    output logic                  src_ready_o,
    output logic                  load_o,
    input  logic                  wready_i,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  wlast_o,
    output logic                  wvalid_o
);

    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  wlast_q;
    logic                  wvalid_q;

    // The register is free when empty or when its beat leaves this edge.
    assign src_ready_o = load_en_i && (!wvalid_q || wready_i);
    assign load_o      = src_valid_i && src_ready_o;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wdata_q  <= '0;
            wlast_q  <= 1'b0;
            wvalid_q <= 1'b0;
        end else if (load_o) begin
            wdata_q  <= src_data_i;
            wlast_q  <= last_i;
            wvalid_q <= 1'b1;
        end else if (wvalid_q && wready_i) begin
            // Data is left in place; only the qualifiers drop.
            wlast_q  <= 1'b0;
            wvalid_q <= 1'b0;
        end
    end

    assign wdata_o  = wdata_q;
    assign wlast_o  = wlast_q;
    assign wvalid_o = wvalid_q;

endmodule

// File: rtl/axi_write_data_channel.sv
// axi_write_data_channel
//   AXI4 write-data / write-response master stage. A level 'go' streams
//   burst_length beats from a local valid/ready source onto W (WLAST on the
//   final beat), then takes the B response and reports done/error.
//   Optional feature: define AXI_WRITE_RESP_TIMEOUT_EN to bound the wait for
//   BVALID to RESP_TIMEOUT cycles (timeout reports error_resp = 2'b11).
//   Ports:
//     clk, resetn                 clock, synchronous active-low reset
//     go                          start request, held until done
//     burst_length, burst_size    beats (1..256), bytes per beat (pow2)
//     src_data/src_valid/src_ready local beat source
//     WDATA/WSTRB/WLAST/WVALID/WREADY  AXI W channel
//     BRESP/BVALID/BREADY         AXI B channel
//     done, error, error_resp     completion status
//     current_state_out           FSM state for debug
module axi_write_data_channel
    import axi_wchan_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int RESP_TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    go,
    input  int                      burst_length,
    input  int                      burst_size,
    input  logic [DATA_WIDTH-1:0]   src_data,
    input  logic                    src_valid,
    output logic                    src_ready,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WLAST,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              error_resp,
    output logic [2:0]              current_state_out
);

    localparam int STRB_W = DATA_WIDTH / 8;

    localparam logic [2:0] S_RESET     = ST_RESET;
    localparam logic [2:0] S_IDLE      = ST_IDLE;
    localparam logic [2:0] S_STREAM    = ST_STREAM;
    localparam logic [2:0] S_WAIT_RESP = ST_WAIT_RESP;
    localparam logic [2:0] S_COMPLETE  = ST_COMPLETE;
    localparam logic [2:0] S_ERROR     = ST_ERROR;

    logic [2:0]        state_q, state_d;
    logic [7:0]        count_q, count_d;          // beats still to be loaded, minus one
    logic              issued_all_q, issued_all_d;
    logic [STRB_W-1:0] strb_q, strb_d;
    logic [1:0]        err_resp_q, err_resp_d;

    logic                  go_legal;
    logic                  in_stream;
    logic                  load_en;
    logic                  src_load;
    logic                  w_last_hs;
    logic [MAX_STRB_W-1:0] strb_full;

    assign go_legal  = size_legal(burst_size, DATA_WIDTH)
                       && (burst_length >= 1) && (burst_length <= MAX_BURST_LEN);
    assign strb_full = size_to_strb(burst_size);
    assign in_stream = (state_q == S_STREAM);
    // Once the final beat has been loaded no further source beats are taken.
    assign load_en   = in_stream && !issued_all_q;
    assign w_last_hs = in_stream && WVALID && WREADY && WLAST;

    axi_w_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk         (clk),
        .resetn      (resetn),
        .load_en_i   (load_en),
        .last_i      (count_q == 8'd0),
        .src_data_i  (src_data),
        .src_valid_i (src_valid),
        .src_ready_o (src_ready),
        .load_o      (src_load),
        .wready_i    (WREADY),
        .wdata_o     (WDATA),
        .wlast_o     (WLAST),
        .wvalid_o    (WVALID)
    );

`ifdef AXI_WRITE_RESP_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
    logic        tmo_hit;

    // Zero outside WAIT_RESP, so it is already clear on entry.
    assign tmo_d   = (state_q == S_WAIT_RESP) ? tmo_q + 16'd1 : 16'd0;
    assign tmo_hit = (tmo_q == 16'(RESP_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tmo_q <= 16'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic tmo_hit;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        issued_all_d = issued_all_q;
        strb_d       = strb_q;
        err_resp_d   = err_resp_q;
        case (state_q)
            S_RESET: begin
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (go) begin
                    if (go_legal) begin
                        state_d      = S_STREAM;
                        count_d      = 8'(burst_length - 1);
                        issued_all_d = 1'b0;
                        strb_d       = strb_full[STRB_W-1:0];
                        err_resp_d   = RESP_OKAY;
                    end else begin
                        state_d    = S_ERROR;
                        err_resp_d = RESP_OKAY;
                    end
                end
            end
            S_STREAM: begin
                if (src_load) begin
                    if (count_q == 8'd0) begin
                        issued_all_d = 1'b1;
                    end else begin
                        count_d = count_q - 8'd1;
                    end
                end
                if (w_last_hs) begin
                    state_d = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (BVALID) begin
                    // BRESP[1] clear means OKAY or EXOKAY.
                    if (!BRESP[1]) begin
                        state_d = S_COMPLETE;
                    end else begin
                        state_d    = S_ERROR;
                        err_resp_d = BRESP;
                    end
                end else if (tmo_hit) begin
                    state_d    = S_ERROR;
                    err_resp_d = RESP_DECERR;
                end
            end
            S_COMPLETE, S_ERROR: begin
                if (!go) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_RESET;
            count_q      <= 8'd0;
            issued_all_q <= 1'b0;
            strb_q       <= '0;
            err_resp_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            issued_all_q <= issued_all_d;
            strb_q       <= strb_d;
            err_resp_q   <= err_resp_d;
        end
    end

    assign WSTRB             = strb_q;
    assign BREADY            = (state_q == S_WAIT_RESP);
    assign done              = (state_q == S_COMPLETE) || (state_q == S_ERROR);
    assign error             = (state_q == S_ERROR);
    assign error_resp        = err_resp_q;
    assign current_state_out = state_q;

endmodule

// File: tb/tb_axi_write_data_channel.sv
// tb_axi_write_data_channel
//   Directed bench for axi_write_data_channel (DATA_WIDTH=32, RESP_TIMEOUT=16).
//   The timeout scenario is included when AXI_WRITE_RESP_TIMEOUT_EN is defined.
module tb_axi_write_data_channel;

  localparam int W = 32;

  logic         clk;
  logic         resetn;
  logic         go;
  int           burst_length;
  int           burst_size;
  logic [W-1:0] src_data;
  logic         src_valid;
  logic         src_ready;
  logic [W-1:0] WDATA;
  logic [3:0]   WSTRB;
  logic         WLAST;
  logic         WVALID;
  logic         WREADY;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY;
  logic         done;
  logic         error;
  logic [1:0]   error_resp;
  logic [2:0]   current_state_out;

  axi_write_data_channel #(
    .DATA_WIDTH   (W),
    .RESP_TIMEOUT (16)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .go                (go),
    .burst_length      (burst_length),
    .burst_size        (burst_size),
    .src_data          (src_data),
    .src_valid         (src_valid),
    .src_ready         (src_ready),
    .WDATA             (WDATA),
    .WSTRB             (WSTRB),
    .WLAST             (WLAST),
    .WVALID            (WVALID),
    .WREADY            (WREADY),
    .BRESP             (BRESP),
    .BVALID            (BVALID),
    .BREADY            (BREADY),
    .done              (done),
    .error             (error),
    .error_resp        (error_resp),
    .current_state_out (current_state_out)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [3:0]   exp_strb;
  int           n_checks = 0;
  int           n_fail   = 0;
  int           hs_cnt   = 0;
  int           cyc      = 0;
  int           first_hs_cyc;
  int           last_hs_cyc;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_last;
  logic [3:0]   prev_strb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // W monitor: at the negedge, WVALID && WREADY means a handshake at the next edge.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("wvalid_held", WVALID, 1'b1);
        check("wdata_held", WDATA, prev_data);
        check("wlast_held", WLAST, prev_last);
        check("wstrb_held", WSTRB, prev_strb);
      end
      if (WVALID && WREADY) begin
        if (hs_cnt == 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_beat", 1'b1, 1'b0);
        end else begin
          check("wlast", WLAST, exp_q.size() == 1);
          check("wdata", WDATA, exp_q.pop_front());
          check("wstrb", WSTRB, exp_strb);
        end
      end
      prev_stall = WVALID && !WREADY;
      prev_data  = WDATA;
      prev_last  = WLAST;
      prev_strb  = WSTRB;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_src(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) begin
      int budget;
      src_data  = base + W'(i);
      src_valid = 1'b1;
      budget    = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (!src_ready && budget < 200);
      if (!src_ready) begin
        check("src_timeout", 1'b0, 1'b1);
        src_valid = 1'b0;
        return;
      end
      tick();
    end
    src_valid = 1'b0;
  endtask

  // mode 0: WREADY held high; mode 1: repeating 1,0,0,1
  task automatic drive_wready(input int mode, input int cycles);
    logic [3:0] pat;
    pat = 4'b1001;
    for (int c = 0; c < cycles; c++) begin
      WREADY = (mode == 0) ? 1'b1 : pat[3 - (c % 4)];
      tick();
    end
    WREADY = 1'b1;
  endtask

  task automatic b_respond(input logic [1:0] resp, input logic exp_err);
    int budget;
    budget = 0;
    while (!BREADY && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!BREADY) begin
      check("bready_timeout", 1'b0, 1'b1);
      return;
    end
    BVALID = 1'b1;
    BRESP  = resp;
    tick();
    BVALID = 1'b0;
    BRESP  = 2'b00;
    check("done_after_b", done, 1'b1);
    check("error_after_b", error, exp_err);
    check("error_resp_after_b", error_resp, exp_err ? resp : 2'b00);
    check("state_after_b", current_state_out, exp_err ? 3'b101 : 3'b100);
  endtask

  task automatic run_burst(input int len, input int size, input logic [3:0] strb,
                           input logic [W-1:0] base, input int mode,
                           input logic [1:0] resp, input logic exp_err);
    for (int i = 0; i < len; i++) exp_q.push_back(base + W'(i));
    exp_strb     = strb;
    hs_cnt       = 0;
    burst_length = len;
    burst_size   = size;
    go           = 1'b1;
    fork
      run_src(len, base);
      drive_wready(mode, 4 * len + 8);
    join
    check("hs_count", hs_cnt, len);
    check("exp_q_empty", exp_q.size(), 0);
    b_respond(resp, exp_err);
    go = 1'b0;
    tick();
    check("back_to_idle", current_state_out, 3'b001);
    check("done_low_idle", done, 1'b0);
  endtask

  task automatic illegal_go(input int len, input int size);
    burst_length = len;
    burst_size   = size;
    go           = 1'b1;
    tick();
    check("illegal_state", current_state_out, 3'b101);
    check("illegal_error", error, 1'b1);
    check("illegal_done", done, 1'b1);
    check("illegal_resp", error_resp, 2'b00);
    tick();
    check("illegal_no_wvalid", WVALID, 1'b0);
    check("illegal_no_src_ready", src_ready, 1'b0);
    go = 1'b0;
    tick();
    check("illegal_to_idle", current_state_out, 3'b001);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    resetn       = 1'b0;
    go           = 1'b0;
    burst_length = 1;
    burst_size   = 4;
    src_data     = '0;
    src_valid    = 1'b0;
    WREADY       = 1'b0;
    BRESP        = 2'b00;
    BVALID       = 1'b0;
    exp_strb     = 4'h0;

    tick();
    tick();
    check("rst_state", current_state_out, 3'b000);
    check("rst_wvalid", WVALID, 1'b0);
    check("rst_wstrb", WSTRB, 4'h0);
    check("rst_done", done, 1'b0);
    check("rst_bready", BREADY, 1'b0);
    resetn = 1'b1;
    tick();
    check("post_rst_idle", current_state_out, 3'b001);

    // 4 beats, full strobes, no stalls, OKAY
    run_burst(4, 4, 4'hF, 32'hA000_0000, 0, 2'b00, 1'b0);
    check("burst4_consecutive", last_hs_cyc - first_hs_cyc, 3);

    // 3 beats under WREADY 1,0,0,1 backpressure, 2-byte beats, EXOKAY
    run_burst(3, 2, 4'h3, 32'hB000_0010, 1, 2'b01, 1'b0);

    // single beat, SLVERR
    run_burst(1, 1, 4'h1, 32'hC000_0020, 0, 2'b10, 1'b1);

    // illegal parameters: error_resp goes 10 -> 00
    illegal_go(4, 3);
    illegal_go(257, 4);
    illegal_go(0, 4);

    // reset after 2 of 8 beats
    begin
      int budget;
      for (int i = 0; i < 8; i++) exp_q.push_back(32'h5A5A_0000);
      exp_strb     = 4'hF;
      hs_cnt       = 0;
      burst_length = 8;
      burst_size   = 4;
      src_data     = 32'h5A5A_0000;
      src_valid    = 1'b1;
      WREADY       = 1'b1;
      go           = 1'b1;
      budget       = 0;
      while (hs_cnt < 2 && budget < 100) begin
        tick();
        budget++;
      end
      check("mid_reset_reached_2", hs_cnt, 2);
      resetn    = 1'b0;
      WREADY    = 1'b0;
      go        = 1'b0;
      src_valid = 1'b0;
      tick();
      check("mid_rst_state", current_state_out, 3'b000);
      check("mid_rst_wvalid", WVALID, 1'b0);
      check("mid_rst_wlast", WLAST, 1'b0);
      check("mid_rst_wdata", WDATA, 32'h0);
      check("mid_rst_wstrb", WSTRB, 4'h0);
      check("mid_rst_src_ready", src_ready, 1'b0);
      check("mid_rst_status", {BREADY, done, error, error_resp}, 5'b0);
      exp_q.delete();
      resetn = 1'b1;
      tick();
    end
    run_burst(8, 4, 4'hF, 32'hD000_0100, 0, 2'b00, 1'b0);

`ifdef AXI_WRITE_RESP_TIMEOUT_EN
    begin
      int budget;
      exp_q.push_back(32'hE000_0000);
      exp_strb     = 4'hF;
      hs_cnt       = 0;
      burst_length = 1;
      burst_size   = 4;
      go           = 1'b1;
      WREADY       = 1'b1;
      run_src(1, 32'hE000_0000);
      budget = 0;
      while (!BREADY && budget < 50) begin
        tick();
        budget++;
      end
      check("tmo_bready", BREADY, 1'b1);
      for (int c = 0; c < 15; c++) tick();
      check("tmo_still_waiting", current_state_out, 3'b011);
      tick();
      check("tmo_state", current_state_out, 3'b101);
      check("tmo_error", error, 1'b1);
      check("tmo_resp", error_resp, 2'b11);
      go = 1'b0;
      tick();
      check("tmo_to_idle", current_state_out, 3'b001);
    end
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
